// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel enable in, counters/syncs/strobes out.
// master = timing generator, slave = pixel pipeline consuming the raster.
interface vga_timing_gen_if #(
    parameter int CW = 12
);
    logic          en;
    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          line_end;
    logic          frame_end;

    modport master (
        input  en,
        output h_count, v_count, hsync, vsync, video_on, line_end, frame_end
    );

    modport slave (
        output en,
        input  h_count, v_count, hsync, vsync, video_on, line_end, frame_end
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA H/V scan engine: counters, polarity-configurable syncs,
// active-video flag, line/frame strobes and an en-qualified sync/video delay line.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int PIPE_DLY = 0,
    parameter int CW       = 12
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master bus
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // Decode word layout: {video_on, hsync, vsync}, syncs already at output polarity.
    localparam logic [2:0] DEC_ORIGIN = {1'b1, ~H_POL, ~V_POL};
    localparam logic [2:0] DEC_IDLE   = {1'b0, ~H_POL, ~V_POL};

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
        $error("vga_timing_gen: horizontal active/porch/sync widths must be >= 1");
    end
    if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
        $error("vga_timing_gen: vertical active/porch/sync widths must be >= 1");
    end
    if (CW < 1 || CW > 30 || (H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_bad_cw
        $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 8) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be within 0..8");
    end

    function automatic logic [2:0] decode(input logic [CW-1:0] h, input logic [CW-1:0] v);
        logic vid;
        logic hs_act;
        logic vs_act;
        vid    = (h < CW'(H_ACTIVE)) && (v < CW'(V_ACTIVE));
        hs_act = (h >= CW'(HS_START)) && (h <= CW'(HS_END));
        vs_act = (v >= CW'(VS_START)) && (v <= CW'(VS_END));
        return {vid, hs_act ? H_POL : ~H_POL, vs_act ? V_POL : ~V_POL};
    endfunction

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic          line_end_q, line_end_d;
    logic          frame_end_q, frame_end_d;
    logic [2:0]    dec_d;
    // Stage 0 is the undelayed decode of the live counters; stage i lags it by i en-steps.
    logic [2:0]    pipe_q [PIPE_DLY+1];

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (bus.en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Outputs decode the next-state counts so they line up with the counters they describe.
    always_comb begin
        line_end_d  = (h_d == H_LAST);
        frame_end_d = (h_d == H_LAST) && (v_d == V_LAST);
        dec_d       = decode(h_d, v_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q         <= '0;
            v_q         <= '0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
            pipe_q[0]   <= DEC_ORIGIN;
            for (int i = 1; i <= PIPE_DLY; i++) begin
                pipe_q[i] <= DEC_IDLE;
            end
        end else if (bus.en) begin
            h_q         <= h_d;
            v_q         <= v_d;
            line_end_q  <= line_end_d;
            frame_end_q <= frame_end_d;
            pipe_q[0]   <= dec_d;
            for (int i = 1; i <= PIPE_DLY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign bus.h_count   = h_q;
    assign bus.v_count   = v_q;
    assign bus.line_end  = line_end_q;
    assign bus.frame_end = frame_end_q;
    assign bus.video_on  = pipe_q[PIPE_DLY][2];
    assign bus.hsync     = pipe_q[PIPE_DLY][1];
    assign bus.vsync     = pipe_q[PIPE_DLY][0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance, a PIPE_DLY=2
// instance, and a short-frame positive-polarity instance for wrap/reset checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst2, rsts;
    int   checks   = 0;
    int   failures = 0;

    vga_timing_gen_if #(.CW(12)) b0 ();
    vga_timing_gen_if #(.CW(12)) b2 ();
    vga_timing_gen_if #(.CW(12)) bs ();

    vga_timing_gen u_def (.clk(clk), .rst(rst0), .bus(b0.master));

    vga_timing_gen #(.PIPE_DLY(2)) u_dly (.clk(clk), .rst(rst2), .bus(b2.master));

    // Short frame: 4 active lines, FP 1, sync lines 5..6, BP 1 -> V_TOTAL 8.
    vga_timing_gen #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1)
    ) u_sml (.clk(clk), .rst(rsts), .bus(bs.master));

    // Expected {video_on, hsync, vsync} for the default horizontal geometry.
    function automatic logic [2:0] exp_dec(input int h, input int v, input int va,
                                           input int vs0, input int vs1,
                                           input bit hp, input bit vp);
        logic vid, hs, vs;
        vid = (h < 640) && (v < va);
        hs  = (h >= 656 && h <= 751) ? hp : !hp;
        vs  = (v >= vs0 && v <= vs1) ? vp : !vp;
        return {vid, hs, vs};
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst0 = 1'b1;
        b0.en = 1'b1;
        tick();
        tick();
        checks++;
        if ({b0.h_count, b0.v_count} !== 24'd0) begin
            failures++;
            $display("FAIL reset_counts got h=%0d v=%0d want h=0 v=0", b0.h_count, b0.v_count);
        end
        checks++;
        if ({b0.video_on, b0.hsync, b0.vsync} !== 3'b111) begin
            failures++;
            $display("FAIL reset_levels got vhv=%b want 111", {b0.video_on, b0.hsync, b0.vsync});
        end
        checks++;
        if ({b0.line_end, b0.frame_end} !== 2'b00) begin
            failures++;
            $display("FAIL reset_strobes got le/fe=%b want 00", {b0.line_end, b0.frame_end});
        end
        rst0 = 1'b0;
        b0.en = 1'b0;
        tick();
        checks++;
        if (b0.h_count !== 12'd0) begin
            failures++;
            $display("FAIL hold_after_reset got h=%0d want 0", b0.h_count);
        end
        $display("reset: default instance at (0,0)");
    endtask

    task automatic test_h_window;
        logic [28:0] got, exp;
        int eh, ev, hs_low, le_cnt, vid_fall;
        hs_low = 0; le_cnt = 0; vid_fall = -1;
        b0.en = 1'b1;
        for (int k = 1; k <= 800; k++) begin
            tick();
            eh = k % 800;
            ev = k / 800;
            exp = {12'(eh), 12'(ev), exp_dec(eh, ev, 480, 490, 491, 1'b0, 1'b0), eh == 799, 1'b0};
            got = {b0.h_count, b0.v_count, b0.video_on, b0.hsync, b0.vsync, b0.line_end, b0.frame_end};
            checks++;
            if (got !== exp) begin
                failures++;
                if (failures < 20) $display("FAIL h_window step=%0d got %h want %h", k, got, exp);
            end
            if (!b0.hsync) hs_low++;
            if (b0.line_end) le_cnt++;
            if (!b0.video_on && vid_fall < 0) vid_fall = int'(b0.h_count);
        end
        b0.en = 1'b0;
        checks++;
        if (hs_low !== 96) begin
            failures++;
            $display("FAIL hsync_width got %0d want 96", hs_low);
        end
        checks++;
        if (vid_fall !== 640) begin
            failures++;
            $display("FAIL video_fall got h=%0d want 640", vid_fall);
        end
        checks++;
        if (le_cnt !== 1) begin
            failures++;
            $display("FAIL line_end_count got %0d want 1", le_cnt);
        end
        $display("h_window: one line, now at (%0d,%0d)", b0.h_count, b0.v_count);
    endtask

    task automatic test_enable_gating;
        logic [28:0] got, exp;
        int eh, ev;
        eh = 0; ev = 1;
        for (int c = 0; c < 3200; c++) begin
            b0.en = (c % 4 == 0);
            tick();
            if (c % 4 == 0) begin
                eh++;
                if (eh == 800) begin eh = 0; ev++; end
            end
            exp = {12'(eh), 12'(ev), exp_dec(eh, ev, 480, 490, 491, 1'b0, 1'b0), eh == 799, 1'b0};
            got = {b0.h_count, b0.v_count, b0.video_on, b0.hsync, b0.vsync, b0.line_end, b0.frame_end};
            checks++;
            if (got !== exp) begin
                failures++;
                if (failures < 20) $display("FAIL en_gating clk=%0d got %h want %h", c, got, exp);
            end
        end
        b0.en = 1'b0;
        checks++;
        if ({b0.h_count, b0.v_count} !== {12'd0, 12'd2}) begin
            failures++;
            $display("FAIL line_3200clk got (%0d,%0d) want (0,2)", b0.h_count, b0.v_count);
        end
        $display("enable_gating: 3200 clks advanced one line");
    endtask

    task automatic test_polarity_reset;
        logic [28:0] got, exp;
        int eh, ev, hs_hi;
        rsts = 1'b1;
        tick();
        rsts = 1'b0;
        bs.en = 1'b1;
        eh = 0; ev = 0; hs_hi = 0;
        for (int k = 1; k <= 2700; k++) begin
            tick();
            eh++;
            if (eh == 800) begin eh = 0; ev++; end
            exp = {12'(eh), 12'(ev), exp_dec(eh, ev, 4, 5, 6, 1'b1, 1'b1), eh == 799, 1'b0};
            got = {bs.h_count, bs.v_count, bs.video_on, bs.hsync, bs.vsync, bs.line_end, bs.frame_end};
            checks++;
            if (got !== exp) begin
                failures++;
                if (failures < 20) $display("FAIL pol_run step=%0d got %h want %h", k, got, exp);
            end
            if (ev == 3 && bs.hsync) hs_hi++;
        end
        checks++;
        if ({bs.h_count, bs.v_count} !== {12'd300, 12'd3}) begin
            failures++;
            $display("FAIL pol_position got (%0d,%0d) want (300,3)", bs.h_count, bs.v_count);
        end
        checks++;
        if (hs_hi !== 0) begin
            failures++;
            $display("FAIL pol_hsync_early got %0d high cycles want 0", hs_hi);
        end
        rsts = 1'b1;
        tick();
        rsts = 1'b0;
        checks++;
        if ({bs.h_count, bs.v_count, bs.hsync, bs.vsync, bs.video_on} !== {24'd0, 3'b001}) begin
            failures++;
            $display("FAIL midframe_reset got (%0d,%0d) hs=%b vs=%b vid=%b want (0,0) 0 0 1",
                     bs.h_count, bs.v_count, bs.hsync, bs.vsync, bs.video_on);
        end
        $display("polarity_reset: mid-frame reset returned to (0,0)");
    endtask

    task automatic test_frame_wrap;
        logic [28:0] got, exp;
        int eh, ev, fe_cnt, vs_hi, hs_hi;
        eh = 0; ev = 0; fe_cnt = 0; vs_hi = 0; hs_hi = 0;
        bs.en = 1'b1;
        for (int k = 1; k <= 6400; k++) begin
            tick();
            eh++;
            if (eh == 800) begin
                eh = 0;
                ev = (ev == 7) ? 0 : ev + 1;
            end
            exp = {12'(eh), 12'(ev), exp_dec(eh, ev, 4, 5, 6, 1'b1, 1'b1), eh == 799,
                   (eh == 799) && (ev == 7)};
            got = {bs.h_count, bs.v_count, bs.video_on, bs.hsync, bs.vsync, bs.line_end, bs.frame_end};
            checks++;
            if (got !== exp) begin
                failures++;
                if (failures < 20) $display("FAIL frame_wrap step=%0d got %h want %h", k, got, exp);
            end
            if (bs.frame_end) fe_cnt++;
            if (bs.vsync) vs_hi++;
            if (bs.hsync && bs.v_count == 12'd1) hs_hi++;
        end
        bs.en = 1'b0;
        checks++;
        if (fe_cnt !== 1) begin
            failures++;
            $display("FAIL frame_end_count got %0d want 1", fe_cnt);
        end
        checks++;
        if (vs_hi !== 1600) begin
            failures++;
            $display("FAIL vsync_lines got %0d cycles want 1600", vs_hi);
        end
        checks++;
        if (hs_hi !== 96) begin
            failures++;
            $display("FAIL pol_hsync_width got %0d want 96", hs_hi);
        end
        checks++;
        if ({bs.h_count, bs.v_count} !== 24'd0) begin
            failures++;
            $display("FAIL frame_wrap_origin got (%0d,%0d) want (0,0)", bs.h_count, bs.v_count);
        end
        $display("frame_wrap: one short frame, frame_end seen %0d time(s)", fe_cnt);
    endtask

    task automatic test_pipeline;
        logic [28:0] got, exp;
        int eh, vid_fall, hs_start;
        vid_fall = -1; hs_start = -1;
        rst2 = 1'b1;
        tick();
        tick();
        checks++;
        if ({b2.video_on, b2.hsync, b2.vsync} !== 3'b011) begin
            failures++;
            $display("FAIL pipe_reset got vhv=%b want 011", {b2.video_on, b2.hsync, b2.vsync});
        end
        rst2 = 1'b0;
        b2.en = 1'b1;
        for (int k = 1; k <= 800; k++) begin
            tick();
            eh = k % 800;
            exp = {12'(eh), 12'(k / 800),
                   (k >= 2) ? exp_dec(k - 2, 0, 480, 490, 491, 1'b0, 1'b0) : 3'b011,
                   eh == 799, 1'b0};
            got = {b2.h_count, b2.v_count, b2.video_on, b2.hsync, b2.vsync, b2.line_end, b2.frame_end};
            checks++;
            if (got !== exp) begin
                failures++;
                if (failures < 20) $display("FAIL pipeline step=%0d got %h want %h", k, got, exp);
            end
            if (k >= 2 && !b2.video_on && vid_fall < 0) vid_fall = int'(b2.h_count);
            if (!b2.hsync && hs_start < 0) hs_start = int'(b2.h_count);
        end
        b2.en = 1'b0;
        checks++;
        if (vid_fall !== 642) begin
            failures++;
            $display("FAIL pipe_video_fall got h=%0d want 642", vid_fall);
        end
        checks++;
        if (hs_start !== 658) begin
            failures++;
            $display("FAIL pipe_hsync_start got h=%0d want 658", hs_start);
        end
        $display("pipeline: video fall at h=%0d, hsync start at h=%0d", vid_fall, hs_start);
    endtask

    initial begin
        rst0 = 1'b1; rst2 = 1'b1; rsts = 1'b1;
        b0.en = 1'b0; b2.en = 1'b0; bs.en = 1'b0;
        tick();
        test_reset();
        test_h_window();
        test_enable_gating();
        test_polarity_reset();
        test_frame_wrap();
        test_pipeline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
